// File: rtl/icache_assoc_pkg.sv
// Shared types and address-field width helpers for the set-associative icache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icache_assoc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Word-offset bits inside a block (0 when a block is a single word).
    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    // Set-index bits (0 for a single set).
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: everything above byte offset, word offset and index.
    function automatic int tag_bits(input int sets, input int words);
        return 30 - $clog2(words) - $clog2(sets);
    endfunction

    // Storage width for a field that may legitimately be zero bits wide.
    function automatic int max1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set age-based LRU tracking and victim selection for the icache.
// Latency: victim is combinational from the read set; age updates land at the next edge.
// Backpressure: none; one update per cycle, driven by the cache controller.
module icache_lru
    import icache_assoc_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int SW = max1(idx_bits(SETS)),
    localparam int WW = max1($clog2(WAYS))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] rd_set_i,
    input  logic [WAYS-1:0] valid_i,
    output logic [WW-1:0] victim_o,
    input  logic          upd_i,
    input  logic [SW-1:0] upd_set_i,
    input  logic [WW-1:0] upd_way_i
);

    localparam int AW = max1($clog2(WAYS));

    logic [AW-1:0] age_q [SETS][WAYS];
    logic [AW-1:0] max_age;
    logic          found;

    // Ages reset to the way number so every set starts as a strict ordering;
    // the touched way becomes youngest and ways younger than it age by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AW'(w);
                end
            end
        end else if (upd_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == upd_way_i) begin
                    age_q[upd_set_i][w] <= '0;
                end else if (age_q[upd_set_i][w] < age_q[upd_set_i][upd_way_i]) begin
                    age_q[upd_set_i][w] <= age_q[upd_set_i][w] + 1'b1;
                end
            end
        end
    end

    // Victim: lowest-numbered invalid way, else the oldest way (lowest index on ties).
    always_comb begin
        victim_o = '0;
        found    = 1'b0;
        max_age  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_i[w]) begin
                victim_o = WW'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            max_age = age_q[rd_set_i][0];
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[rd_set_i][w] > max_age) begin
                    max_age  = age_q[rd_set_i][w];
                    victim_o = WW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU replacement, flush and hit/miss counters.
// Latency: hits are combinational (zero cycles); a miss hits again WORDS accepted transfers + 2 cycles later.
// Backpressure: fills stall on iwait with iaddr held; fetches are not accepted outside IDLE.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int CPUID = 0,
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output word_t       imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  word_t       iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OB = off_bits(WORDS);
    localparam int TB = tag_bits(SETS, WORDS);
    localparam int OW = max1(OB);
    localparam int SW = max1(idx_bits(SETS));
    localparam int WW = max1($clog2(WAYS));

    typedef logic [TB-1:0] tag_t;

    function automatic logic [SW-1:0] set_of(input logic [31:0] a);
        return SW'((a >> (2 + OB)) & (SETS - 1));
    endfunction

    function automatic logic [OW-1:0] off_of(input logic [31:0] a);
        return OW'((a >> 2) & (WORDS - 1));
    endfunction

    // Parameter legality; CPUID is trace-only and just has to be a sane id.
    a_params: assert property (@(posedge CLK)
        (SETS >= 1) && (WAYS >= 1) && (WAYS <= 8) && (WORDS >= 1) && (WORDS <= 8) && (CPUID >= 0));

    word_t           data_q  [SETS][WAYS][WORDS];
    tag_t            tag_q   [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    word_t           buf_q   [WORDS];

    state_t          state_q;
    logic [31:0]     base_q;
    logic [WW-1:0]   way_q;
    logic [OW-1:0]   k_q;
    logic            iren_q;
    logic [31:0]     iaddr_q;
    logic [31:0]     hit_count_q;
    logic [31:0]     miss_count_q;

    logic [SW-1:0]   rd_set;
    logic [OW-1:0]   rd_off;
    tag_t            rd_tag;
    logic [SW-1:0]   fill_set;
    logic            tag_hit;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   victim;
    logic            fill_start;
    logic            write_commit;

    assign rd_set   = set_of(imemaddr);
    assign rd_off   = off_of(imemaddr);
    assign rd_tag   = imemaddr[31 -: TB];
    assign fill_set = set_of(base_q);

    // Tag compare across the ways of the addressed set.
    always_comb begin
        tag_hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[rd_set][w] && (tag_q[rd_set][w] == rd_tag)) begin
                tag_hit = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // A flush in the same cycle masks the hit so it is neither returned nor counted.
    assign ihit         = imemREN && (state_q == IDLE) && !flush && tag_hit;
    assign imemload     = ihit ? data_q[rd_set][hit_way][rd_off] : '0;
    assign fill_start   = imemREN && (state_q == IDLE) && !flush && !tag_hit;
    assign write_commit = (state_q == WRITE) && !flush;

    assign iREN       = iren_q;
    assign iaddr      = iaddr_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    icache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk       (CLK),
        .rst       (RST),
        .rd_set_i  (rd_set),
        .valid_i   (valid_q[rd_set]),
        .victim_o  (victim),
        .upd_i     (ihit || write_commit),
        .upd_set_i (ihit ? rd_set : fill_set),
        .upd_way_i (ihit ? hit_way : way_q)
    );

    // Fill controller: latch the miss, stream WORDS words from memory, then one write cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            base_q  <= '0;
            way_q   <= '0;
            k_q     <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        state_q <= FILL;
                        base_q  <= imemaddr & ~32'(WORDS * 4 - 1);
                        iaddr_q <= imemaddr & ~32'(WORDS * 4 - 1);
                        way_q   <= victim;
                        k_q     <= '0;
                        iren_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (flush) begin
                        state_q <= IDLE;
                        iren_q  <= 1'b0;
                        iaddr_q <= '0;
                    end else if (!iwait) begin
                        if (k_q == OW'(WORDS - 1)) begin
                            state_q <= WRITE;
                            iren_q  <= 1'b0;
                            iaddr_q <= '0;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            iaddr_q <= iaddr_q + 32'd4;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                    iaddr_q <= '0;
                end
            endcase
        end
    end

    // Capture each accepted memory word into the fill buffer.
    always_ff @(posedge CLK) begin
        if ((state_q == FILL) && !flush && !iwait) begin
            buf_q[k_q] <= iload;
        end
    end

    // Commit the completed block and its tag into the victim way.
    always_ff @(posedge CLK) begin
        if (write_commit) begin
            for (int i = 0; i < WORDS; i++) begin
                data_q[fill_set][way_q][i] <= buf_q[i];
            end
            tag_q[fill_set][way_q] <= base_q[31 -: TB];
        end
    end

    // Valid bits: cleared by reset or flush, set when a fill commits.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (state_q == WRITE) begin
            valid_q[fill_set][way_q] <= 1'b1;
        end
    end

    // Saturating statistics: hits per hit cycle, misses per fill started.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (fill_start && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc (SETS=8, WAYS=2, WORDS=2).
// Latency: memory model answers combinationally; iwait is driven per scenario.
// Backpressure: stall scenario holds iwait high on the first word.
module tb_icache_assoc;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    icache_assoc #(
        .CPUID (0),
        .SETS  (8),
        .WAYS  (2),
        .WORDS (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    assign iload = mem_word(iaddr);

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; imemREN = 1'b0; flush = 1'b0; iwait = 1'b0; imemaddr = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Present a fetch and wait (bounded) for the hit; leaves one counted hit cycle.
    task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] data);
        imemREN = 1'b1; imemaddr = a; #1;
        lat = 0;
        while (!ihit && lat < 200) begin
            @(negedge CLK); #1;
            lat++;
        end
        data = imemload;
        @(negedge CLK);
        imemREN = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h40; #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iren got %0b want 0", iREN); end
        checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h want 0", iaddr); end
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got %0b want 0", ihit); end
        checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload got %h want 0", imemload); end
        checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count);
        end
        imemREN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_cold_miss();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; #1;
        checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++; $display("FAIL cold_c0 ihit/iREN got %0b/%0b want 0/0", ihit, iREN);
        end
        @(negedge CLK); #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin
            errors++; $display("FAIL cold_word0 iREN/iaddr got %0b/%h want 1/00000040", iREN, iaddr);
        end
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_miss_count got %0d want 1", miss_count); end
        @(negedge CLK); #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            errors++; $display("FAIL cold_word1 iREN/iaddr got %0b/%h want 1/00000044", iREN, iaddr);
        end
        @(negedge CLK); #1;
        checks++; if (iREN !== 1'b0 || ihit !== 1'b0) begin
            errors++; $display("FAIL cold_write iREN/ihit got %0b/%0b want 0/0", iREN, ihit);
        end
        @(negedge CLK); #1;
        checks++; if (ihit !== 1'b1 || imemload !== mem_word(32'h40)) begin
            errors++; $display("FAIL cold_hit40 ihit/data got %0b/%h want 1/%h", ihit, imemload, mem_word(32'h40));
        end
        @(negedge CLK);
        imemaddr = 32'h44; #1;
        checks++; if (ihit !== 1'b1 || imemload !== mem_word(32'h44) || iREN !== 1'b0) begin
            errors++; $display("FAIL cold_hit44 ihit/data/iREN got %0b/%h/%0b want 1/%h/0", ihit, imemload, iREN, mem_word(32'h44));
        end
        @(negedge CLK);
        imemREN = 1'b0; #1;
        checks++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
            errors++; $display("FAIL cold_counters hit/miss got %0d/%0d want 2/1", hit_count, miss_count);
        end
    endtask

    task automatic test_flush_idle();
        int lat;
        logic [31:0] d;
        imemREN = 1'b1; imemaddr = 32'h40; #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL flush_idle_prehit got %0b want 1", ihit); end
        flush = 1'b1; #1;
        checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_idle_mask got %0b want 0", ihit); end
        @(negedge CLK);
        flush = 1'b0; imemREN = 1'b0; #1;
        checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL flush_idle_hitcnt got %0d want 2", hit_count); end
        fetch(32'h40, lat, d);
        checks++; if (lat !== 4 || d !== mem_word(32'h40)) begin
            errors++; $display("FAIL flush_idle_refill lat/data got %0d/%h want 4/%h", lat, d, mem_word(32'h40));
        end
        checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL flush_idle_misscnt got %0d want 2", miss_count); end
    endtask

    task automatic test_conflict_lru();
        int lat;
        logic [31:0] d;
        logic [31:0] addrs [6];
        int          lats  [6];
        addrs = '{32'h00, 32'h40, 32'h00, 32'h80, 32'h00, 32'h40};
        lats  = '{4, 4, 0, 4, 0, 4};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fetch(addrs[i], lat, d);
            checks++; if (lat !== lats[i] || d !== mem_word(addrs[i])) begin
                errors++; $display("FAIL lru_step%0d addr %h lat/data got %0d/%h want %0d/%h",
                                   i, addrs[i], lat, d, lats[i], mem_word(addrs[i]));
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        do_reset();
        iwait = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1; lat++;
            checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin
                errors++; $display("FAIL stall_cycle%0d iREN/iaddr got %0b/%h want 1/00000040", i, iREN, iaddr);
            end
        end
        @(negedge CLK); lat++;
        iwait = 1'b0; #1;
        while (!ihit && lat < 200) begin
            @(negedge CLK); #1; lat++;
        end
        checks++; if (lat !== 9 || imemload !== mem_word(32'h40)) begin
            errors++; $display("FAIL stall_done lat/data got %0d/%h want 9/%h", lat, imemload, mem_word(32'h40));
        end
        @(negedge CLK);
        imemREN = 1'b0;
    endtask

    task automatic test_flush_fill();
        int lat;
        logic [31:0] d;
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
        @(negedge CLK);
        @(negedge CLK); #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            errors++; $display("FAIL flush_fill_pre iREN/iaddr got %0b/%h want 1/00000044", iREN, iaddr);
        end
        flush = 1'b1; imemREN = 1'b0;
        @(negedge CLK);
        flush = 1'b0; #1;
        checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++; $display("FAIL flush_fill_abort iREN/iaddr got %0b/%h want 0/0", iREN, iaddr);
        end
        fetch(32'h40, lat, d);
        checks++; if (lat !== 4 || d !== mem_word(32'h40)) begin
            errors++; $display("FAIL flush_fill_refetch lat/data got %0d/%h want 4/%h", lat, d, mem_word(32'h40));
        end
        checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL flush_fill_misscnt got %0d want 2", miss_count); end
    endtask

    task automatic test_reset_mid_fill();
        int lat;
        logic [31:0] d;
        imemREN = 1'b1; imemaddr = 32'h100;
        @(negedge CLK); #1;
        checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin
            errors++; $display("FAIL rstfill_pre iREN/iaddr got %0b/%h want 1/00000100", iREN, iaddr);
        end
        RST = 1'b1; imemREN = 1'b0;
        @(negedge CLK); #1;
        checks++; if (iREN !== 1'b0 || iaddr !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++; $display("FAIL rstfill_post iREN/iaddr/hit/miss got %0b/%h/%0d/%0d want 0/0/0/0",
                               iREN, iaddr, hit_count, miss_count);
        end
        RST = 1'b0;
        @(negedge CLK);
        fetch(32'h40, lat, d);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstfill_lookup lat got %0d want 4", lat); end
    endtask

    task automatic test_saturation();
        imemREN = 1'b1; imemaddr = 32'h40;
        force dut.hit_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_count_q;
        #1;
        checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL sat_hit got %0b want 1", ihit); end
        @(negedge CLK); #1;
        checks++; if (hit_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach got %h want ffffffff", hit_count); end
        @(negedge CLK); #1;
        checks++; if (hit_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h want ffffffff", hit_count); end
        imemREN = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_flush_idle();
        test_conflict_lru();
        test_stall();
        test_flush_fill();
        test_reset_mid_fill();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache; next generation of the per-CPU direct-mapped icache.
- Sits between the datapath fetch port and the memory-controller instruction port. Instantiated once per core alongside the dcache.
- Adds configurable sets, ways and block size, LRU replacement, a flush input, and hit/miss statistics counters.

Parameters:
- CPUID, 0, core identifier; carried for tracing, no functional effect.
- SETS, 8, number of sets; power of 2, at least 1.
- WAYS, 2, associativity; power of 2, 1 to 8.
- WORDS, 2, 32-bit words per block; power of 2, 1 to 8.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  fetched instruction; valid when ihit=1.
- flush  in  1  invalidate all lines.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address; bits [1:0]=0.
- iwait  in  1  memory busy; a word is accepted in a cycle with iREN=1 and iwait=0.
- iload  in  32  memory read data, sampled when iREN=1 and iwait=0.
- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of fills started.

Behaviour:
- Address split, LSB to MSB:
  - byte offset 2b;
  - word offset clog2(WORDS);
  - index clog2(SETS);
  - tag = remaining bits.
- Reset (RST=1 at a clock edge) does all of the following:
  - clears all valid bits, LRU state, fill state and both counters;
  - forces state IDLE, so iREN=0 and iaddr=0;
  - ihit=0 follows from every line being invalid.
- Hit is combinational: ihit = imemREN & state==IDLE & the tag matches a valid way of the indexed set.
  - imemload = that way's addressed word; otherwise imemload=0.
  - Zero-cycle latency.
- LRU: per set, an age of clog2(WAYS) bits per way. On a hit, or on fill completion, into way w:
  - w's age becomes 0;
  - ways younger than w's old age increment;
  - all other ages are unchanged.
- Victim selection: the lowest-numbered invalid way; if none is invalid, the way with the maximum age.
- FSM IDLE:
  - on imemREN & miss & !flush, latch the block base address, victim way and k=0, increment miss_count, go to FILL.
  - Counting rules: miss_count increments once per fill start. hit_count increments once per cycle where ihit=1.
- FSM FILL:
  - iREN=1, iaddr = base + 4*k.
  - When iwait=0, store iload into the fill buffer word k.
  - If k==WORDS-1, go to WRITE; otherwise k++.
  - iwait may stay high indefinitely; iaddr holds stable while it does.
- FSM WRITE (one cycle):
  - write the buffer, tag and valid=1 into the victim way;
  - update LRU;
  - go to IDLE.
  - The datapath re-presents the address and hits on the next cycle.
  - Fill-to-hit latency = WORDS accepted transfers + 2 cycles.
- flush:
  - in IDLE or WRITE: all valid bits cleared at the next edge; a WRITE in the same cycle is discarded; ihit forced 0 that cycle.
  - in FILL: the fill is aborted, with iREN dropping the next cycle; return to IDLE, no line written, miss_count not decremented.
- Simultaneous hit and flush: ihit=0 and the hit is not counted.
- imemREN dropping or the address changing mid-fill: the fill completes for the latched address; no abort.
- Both counters saturate at 32'hFFFF_FFFF.

Decomposition:
- Package icache_assoc_pkg holds: the word_t typedef (32b), the FSM state enum {IDLE, FILL, WRITE}, and address-field width functions derived from the parameters.
- One sub-module, icache_lru, holds the per-set age array, the hit/fill update logic and victim selection (parameters SETS, WAYS).

Test Plan:
- Cold miss, SETS=8 WAYS=2 WORDS=2, fetch 0x40, iwait=0 -> iaddr 0x40 then 0x44 on consecutive cycles, WRITE, next cycle ihit=1 with word@0x40; fetch 0x44 -> hit, no iREN; miss_count=1, hit_count=2.
- Conflict/LRU:
  - fill 0x00, then fill 0x40 (same set 0), then hit 0x00, then fetch 0x80;
  - -> 0x80 evicts the 0x40 way; 0x00 still hits afterwards; 0x40 misses.
- Stall: iwait held high 5 cycles on the first word -> iREN=1 and iaddr=0x40 stable throughout; completion delayed exactly 5 cycles; data correct.
- Flush:
  - flush asserted during FILL after word 0 -> iREN=0 next cycle; re-fetch of the same address misses again; miss_count=2.
  - flush in IDLE -> all prior hits now miss.
- Reset mid-fill: RST=1 during FILL -> next cycle iREN=0, iaddr=0, counters 0, all lookups miss.
- Counter saturation: preload hit_count to 32'hFFFF_FFFF via forced state, then hit -> stays 32'hFFFF_FFFF.
